// File: rtl/pll_clk_manager.sv
// pll_clk_manager: supervises an external PLL (reset, lock sync, lock timeout
// with retry), sequences the system reset from lock status, and generates
// NUM_CH programmable clock-enable / square-wave divider channels.
module pll_clk_manager #(
  parameter int NUM_CH         = 2,
  parameter int DIV_W          = 16,
  parameter int DIV_RESET      = 0,
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 1000,
  parameter int HOLD_CYCLES    = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock_i,
  output logic              pll_rst_o,
  output logic              sys_rst_o,
  output logic              locked_o,
  output logic [7:0]        retry_cnt_o,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] sq_o
);

  // Timer must hold the largest terminal count of any state.
  localparam int TMAX_A    = (LOCK_TIMEOUT > HOLD_CYCLES) ? LOCK_TIMEOUT : HOLD_CYCLES;
  localparam int TIMER_MAX = (TMAX_A > PLL_RST_CYCLES) ? TMAX_A : PLL_RST_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           retry_q, retry_d;
  logic                 pll_rst_q, pll_rst_d;
  logic                 sys_rst_q, sys_rst_d;
  logic                 locked_q, locked_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                 lock_s;

  logic [DIV_W-1:0]     div_q [NUM_CH];
  logic [DIV_W-1:0]     div_d [NUM_CH];
  logic [DIV_W-1:0]     cnt_q [NUM_CH];
  logic [DIV_W-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0]    ce_q, ce_d;
  logic [NUM_CH-1:0]    sq_q, sq_d;
  logic                 run_keep;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous lock input through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], lock_i};
  end

  // Next-state logic for the lock supervisor; the timer restarts on every transition.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    timer_d = timer_q + TIMER_W'(1);
    retry_d = retry_q;
    unique case (state_q)
      S_PLL_RST: begin
        if (timer_q == TIMER_W'(PLL_RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          timer_d = '0;
        end else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) begin
          state_d = S_PLL_RST;
          timer_d = '0;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == TIMER_W'(HOLD_CYCLES - 1)) begin
          state_d = S_RUN;
          timer_d = '0;
        end
      end
      S_RUN: begin
        timer_d = '0;
        if (!lock_s) state_d = S_WAIT_LOCK;
      end
      default: begin
        state_d = S_PLL_RST;
        timer_d = '0;
      end
    endcase
    pll_rst_d = (state_d == S_PLL_RST);
    sys_rst_d = (state_d != S_RUN);
    locked_d  = (state_d == S_RUN);
  end

  // Divider channels: writes win over wraps; leaving or being outside RUN clears everything but the divisor.
  always_comb begin
    run_keep = (state_q == S_RUN) && (state_d == S_RUN);
    ce_d     = '0;
    sq_d     = sq_q;
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      if (wr_en && (wr_ch == 3'(i))) begin
        div_d[i] = wr_div;
        cnt_d[i] = '0;
      end else if (run_keep) begin
        if (cnt_q[i] == div_q[i]) begin
          cnt_d[i] = '0;
          ce_d[i]  = 1'b1;
          sq_d[i]  = ~sq_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DIV_W'(1);
        end
      end
      if (!run_keep) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
      end
    end
  end

  // State register with synchronous reset; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= S_PLL_RST;
      timer_q   <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      locked_q  <= locked_d;
      sync_q    <= sync_d;
    end
  end

  // Channel registers; divisors are reset too because software expects DIV_RESET after rst.
  always_ff @(posedge clk) begin
    // NOTE: this small divisor array is flop-based, so resetting it is legal and cheap (unlike RAM).
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(DIV_RESET);
        cnt_q[i] <= '0;
      end
      ce_q <= '0;
      sq_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      ce_q <= ce_d;
      sq_q <= sq_d;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign locked_o    = locked_q;
  assign retry_cnt_o = retry_q;
  assign ce_o        = ce_q;
  assign sq_o        = sq_q;

endmodule

// File: tb/tb_pll_clk_manager.sv
// Directed, table-driven bench for pll_clk_manager.
module tb_pll_clk_manager;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lock_i = 1'b0;
  logic        pll_rst_o, sys_rst_o, locked_o;
  logic [7:0]  retry_cnt_o;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_ch = '0;
  logic [15:0] wr_div = '0;
  logic [1:0]  ce_o, sq_o;

  int n_checks = 0;
  int n_err    = 0;

  pll_clk_manager #(
    .NUM_CH(2), .DIV_W(16), .DIV_RESET(0), .SYNC_STAGES(2),
    .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20), .HOLD_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .lock_i(lock_i),
    .pll_rst_o(pll_rst_o), .sys_rst_o(sys_rst_o), .locked_o(locked_o),
    .retry_cnt_o(retry_cnt_o),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
    .ce_o(ce_o), .sq_o(sq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        rst, lock, we;
    logic [2:0]  ch;
    logic [15:0] div;
    logic        pll, sys, lk;
    logic [7:0]  retry;
    logic [1:0]  ce, sq;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input int n, input logic r, input logic lk_in, input logic we,
                              input logic [2:0] ch, input logic [15:0] div,
                              input logic pll, input logic sys, input logic lk,
                              input logic [7:0] retry, input logic [1:0] ce, input logic [1:0] sq);
    vec_t v;
    v.n = n; v.rst = r; v.lock = lk_in; v.we = we; v.ch = ch; v.div = div;
    v.pll = pll; v.sys = sys; v.lk = lk; v.retry = retry; v.ce = ce; v.sq = sq;
    vq.push_back(v);
  endfunction

  // Apply each vector for n edges, checking outputs 1 time unit after every edge.
  task automatic run_vectors(input string tag);
    for (int k = 0; k < vq.size(); k++) begin
      for (int c = 0; c < vq[k].n; c++) begin
        rst    = vq[k].rst;
        lock_i = vq[k].lock;
        wr_en  = vq[k].we;
        wr_ch  = vq[k].ch;
        wr_div = vq[k].div;
        @(posedge clk);
        #1;
        check($sformatf("%s[%0d.%0d] pll_rst", tag, k, c), 32'(pll_rst_o),   32'(vq[k].pll));
        check($sformatf("%s[%0d.%0d] sys_rst", tag, k, c), 32'(sys_rst_o),   32'(vq[k].sys));
        check($sformatf("%s[%0d.%0d] locked",  tag, k, c), 32'(locked_o),    32'(vq[k].lk));
        check($sformatf("%s[%0d.%0d] retry",   tag, k, c), 32'(retry_cnt_o), 32'(vq[k].retry));
        check($sformatf("%s[%0d.%0d] ce",      tag, k, c), 32'(ce_o),        32'(vq[k].ce));
        check($sformatf("%s[%0d.%0d] sq",      tag, k, c), 32'(sq_o),        32'(vq[k].sq));
      end
    end
    wr_en = 1'b0;
    vq.delete();
  endtask

  initial begin
    logic       held_bad;
    logic       mono_bad;
    logic [7:0] prev_retry;

    // ---- Table A: reset, clean lock, divider, lock loss, timeout retries ----
    //   n   rst lck we ch    div     pll sys lk retry ce     sq
    add(2,  1, 0, 0, 3'd0, 16'd0,  1, 1, 0, 8'd0, 2'b00, 2'b00); // reset state
    add(3,  0, 1, 0, 3'd0, 16'd0,  1, 1, 0, 8'd0, 2'b00, 2'b00); // PLL reset held
    add(9,  0, 1, 0, 3'd0, 16'd0,  0, 1, 0, 8'd0, 2'b00, 2'b00); // wait + hold
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b00, 2'b00); // enter RUN
    add(1,  0, 1, 1, 3'd0, 16'd3,  0, 0, 1, 8'd0, 2'b10, 2'b10); // ch0 D=3, ch1 wraps (D=0)
    add(1,  0, 1, 1, 3'd1, 16'd0,  0, 0, 1, 8'd0, 2'b00, 2'b10); // ch1 write: no ce, sq held
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b10, 2'b00);
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b10, 2'b10);
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b11, 2'b01); // first ch0 ce
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b10, 2'b11);
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b10, 2'b01);
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b10, 2'b11);
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b11, 2'b00); // ch0 ce 4 cycles later
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b10, 2'b10);
    add(1,  0, 1, 1, 3'd0, 16'd1,  0, 0, 1, 8'd0, 2'b10, 2'b00); // ch0 D=1 mid-count
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b10, 2'b10);
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b11, 2'b01); // ce 2 cycles after write
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b10, 2'b11);
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b11, 2'b00);
    add(1,  0, 1, 1, 3'd5, 16'd7,  0, 0, 1, 8'd0, 2'b10, 2'b10); // wr_ch=5 ignored
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b11, 2'b01);
    add(1,  0, 0, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b10, 2'b11); // lock dropped, still RUN
    add(1,  0, 0, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b11, 2'b00); // sync delay
    add(20, 0, 0, 0, 3'd0, 16'd0,  0, 1, 0, 8'd0, 2'b00, 2'b00); // WAIT_LOCK, no PLL reset
    add(4,  0, 0, 0, 3'd0, 16'd0,  1, 1, 0, 8'd1, 2'b00, 2'b00); // timeout retry 1
    add(20, 0, 0, 0, 3'd0, 16'd0,  0, 1, 0, 8'd1, 2'b00, 2'b00);
    add(4,  0, 0, 0, 3'd0, 16'd0,  1, 1, 0, 8'd2, 2'b00, 2'b00); // retry 2
    add(20, 0, 0, 0, 3'd0, 16'd0,  0, 1, 0, 8'd2, 2'b00, 2'b00);
    add(1,  0, 0, 0, 3'd0, 16'd0,  1, 1, 0, 8'd3, 2'b00, 2'b00); // retry 3
    run_vectors("A");

    // ---- Saturation: keep lock low for well over 256 retries ----
    held_bad   = 1'b0;
    mono_bad   = 1'b0;
    prev_retry = retry_cnt_o;
    lock_i     = 1'b0;
    for (int c = 0; c < 256 * 24; c++) begin
      @(posedge clk);
      #1;
      if (sys_rst_o !== 1'b1 || locked_o !== 1'b0) held_bad = 1'b1;
      if (retry_cnt_o < prev_retry) mono_bad = 1'b1;
      prev_retry = retry_cnt_o;
    end
    check("sat_retry_cnt",    32'(retry_cnt_o), 32'd255);
    check("sat_sys_rst_held", 32'(held_bad),    32'd0);
    check("sat_no_wrap",      32'(mono_bad),    32'd0);

    // ---- Table B: rst clears retries/divisors, then glitchy lock ----
    add(2,  1, 0, 0, 3'd0, 16'd0,  1, 1, 0, 8'd0, 2'b00, 2'b00); // rst clears retry count
    add(3,  0, 0, 0, 3'd0, 16'd0,  1, 1, 0, 8'd0, 2'b00, 2'b00);
    add(1,  0, 0, 0, 3'd0, 16'd0,  0, 1, 0, 8'd0, 2'b00, 2'b00);
    add(5,  0, 1, 0, 3'd0, 16'd0,  0, 1, 0, 8'd0, 2'b00, 2'b00); // high 5
    add(1,  0, 0, 0, 3'd0, 16'd0,  0, 1, 0, 8'd0, 2'b00, 2'b00); // low 1
    add(10, 0, 1, 0, 3'd0, 16'd0,  0, 1, 0, 8'd0, 2'b00, 2'b00); // hold restarts
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b00, 2'b00); // RUN
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b11, 2'b11); // both divisors back to 0
    add(1,  0, 1, 0, 3'd0, 16'd0,  0, 0, 1, 8'd0, 2'b11, 2'b00);
    run_vectors("B");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_clk_manager.md
Name: pll_clk_manager

Overview:
- Supervises an external PLL and generates the SoC's derived timing.
- Functions:
  - drives the PLL reset and synchronises its LOCK output;
  - filters and times out lock acquisition, retrying the PLL on timeout;
  - sequences the system reset from lock status;
  - produces NUM_CH runtime-programmable clock-enable / divided-square-wave channels.
- Sits between the PLL primitive instance and the SoC core, in the PLL output clock domain.

Parameters:
- NUM_CH, 2, number of divider channels (1..8)
- DIV_W, 16, divisor width per channel
- DIV_RESET, 0, reset divisor value for all channels
- SYNC_STAGES, 2, flop stages on lock_i (>=2)
- PLL_RST_CYCLES, 4, cycles pll_rst_o is held high per PLL reset
- LOCK_TIMEOUT, 1000, cycles to wait for lock before retrying the PLL
- HOLD_CYCLES, 256, consecutive locked cycles required before releasing the system reset

Ports:
- clk  in  1  PLL output clock; all logic on the rising edge
- rst  in  1  synchronous active-high reset
- lock_i  in  1  PLL LOCK, asynchronous
- pll_rst_o  out  1  PLL RESET request
- sys_rst_o  out  1  system reset, active high
- locked_o  out  1  high in RUN state only
- retry_cnt_o  out  8  saturating count of timeout-triggered PLL resets
- wr_en  in  1  divisor write strobe
- wr_ch  in  3  channel index for the write
- wr_div  in  DIV_W  divisor value
- ce_o  out  NUM_CH  one-cycle clock-enable pulse per channel
- sq_o  out  NUM_CH  divided square wave per channel

Behaviour:
- Reset values (rst=1 at an edge):
  - state=PLL_RST, timer=0
  - pll_rst_o=1, sys_rst_o=1, locked_o=0, retry_cnt_o=0
  - ce_o=0, sq_o=0, all channel counters 0, all divisors=DIV_RESET
- lock_s is lock_i delayed by SYNC_STAGES flops. Sync flops reset to 0.
- All outputs are registered: they reflect the state/counters after the edge.
- State machine; timer is cleared on every state transition:
  - PLL_RST:
    - pll_rst_o=1.
    - After PLL_RST_CYCLES cycles in state -> WAIT_LOCK.
    - lock_s is ignored.
  - WAIT_LOCK:
    - pll_rst_o=0; timer increments.
    - lock_s=1 -> STABLE.
    - Otherwise, when timer reaches LOCK_TIMEOUT-1 -> PLL_RST, and retry_cnt_o += 1, saturating at 255.
  - STABLE:
    - lock_s=0 -> WAIT_LOCK. No retry increment; timeout restarts from 0.
    - After HOLD_CYCLES consecutive cycles with lock_s=1 -> RUN.
  - RUN:
    - sys_rst_o=0, locked_o=1.
    - lock_s=0 -> WAIT_LOCK. sys_rst_o=1 and locked_o=0 from the next edge.
- sys_rst_o = 1 in every state except RUN.
- Channel i, divisor D:
  - Counter runs only in RUN. Outside RUN: counter=0, ce_o[i]=0, sq_o[i] holds 0.
  - Leaving RUN forces sq_o[i]=0 at the same edge that asserts sys_rst_o.
  - In RUN: counter counts 0..D, wrapping to 0.
  - ce_o[i]=1 for the single cycle following the edge at which the counter wraps. Period is D+1 cycles; D=0 gives ce_o[i] constantly 1.
  - sq_o[i] toggles at each wrap, giving period 2(D+1).
  - First ce_o[i] occurs D+1 cycles after entering RUN.
- Divisor writes:
  - Accepted in any state when rst=0.
  - The target divisor updates, and its counter clears to 0, at the write edge.
  - No ce is emitted at that edge; sq_o is unchanged.
  - Writes with wr_ch >= NUM_CH are ignored.
  - A write coinciding with a wrap takes priority: counter -> 0, no ce, no toggle.
- Arithmetic: timer is wide enough for max(LOCK_TIMEOUT, HOLD_CYCLES, PLL_RST_CYCLES) and never wraps in use.
- rst mid-operation (any state) returns everything to reset values at that edge, including retry_cnt_o and divisors.

Test Plan:
Parameters for all runs: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, HOLD_CYCLES=8, D=3 on channel 0.
1. Clean lock:
   - Stimulus: lock_i=1 from cycle 0 after rst release.
   - Required: pll_rst_o high 4 cycles; sys_rst_o falls after the sync delay + 8 hold cycles; locked_o rises at the same edge; retry_cnt_o=0.
2. Timeout retry:
   - Stimulus: lock_i=0 for 60 cycles.
   - Required: pll_rst_o pulses 4 cycles wide, with 20-cycle waits between pulses; retry_cnt_o counts 1,2,...; sys_rst_o stays 1.
3. Glitchy lock:
   - Stimulus: lock_i high 5 cycles, low 1, then high.
   - Required: no RUN until 8 consecutive synced-high cycles; retry_cnt_o unchanged.
4. Divider:
   - Stimulus: in RUN, write ch0 D=3, then ch1 D=0.
   - Required: ce_o[0] pulses every 4 cycles and sq_o[0] has period 8; ce_o[1] is constant 1 and sq_o[1] toggles every cycle.
   - Also: write ch0 D=1 mid-count -> counter restarts, next ce 2 cycles later; wr_ch=5 -> no effect.
5. Lock loss in RUN:
   - Stimulus: drop lock_i.
   - Required: sys_rst_o=1 and ce_o=0 two cycles + 1 edge later; state returns to WAIT_LOCK with no PLL reset unless 20 cycles pass unlocked.
6. Saturation:
   - Stimulus: hold lock_i=0 for >256 retries.
   - Required: retry_cnt_o=255.
   - Then: assert rst -> retry_cnt_o=0 and divisors=DIV_RESET.
